// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings,
// FSM state type, default timeout and the alignment rule.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  localparam int TIMEOUT_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_R,
    ST_ERR,
    ST_DONE
  } lsu_state_e;

  // Halves need an even address, words a multiple of four; the reserved
  // size code can never be issued and is reported like a misalignment.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = off[0];
      SZ_W:    mis = (off != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering between the core and a 32-bit memory word:
// store-data replication with byte enables, and load extract/extend.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] ld_word_i,
  output logic [3:0]  be_o,
  output logic [31:0] st_word_o,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        sext;

  // Replicate store data across all lanes so memory only needs the enables
  always_comb begin
    st_word_o = st_data_i;
    be_o      = 4'b1111;
    if (we_i) begin
      case (size_i)
        SZ_B: begin
          st_word_o = {4{st_data_i[7:0]}};
          be_o      = 4'b0001 << off_i;
        end
        SZ_H: begin
          st_word_o = {2{st_data_i[15:0]}};
          be_o      = off_i[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          st_word_o = st_data_i;
          be_o      = 4'b1111;
        end
      endcase
    end
  end

  // Pick the addressed byte/half out of the read word and extend it
  always_comb begin
    ld_byte = ld_word_i[{off_i, 3'b000} +: 8];
    ld_half = off_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
    sext    = ~unsigned_i;
    case (size_i)
      SZ_B:    ld_data_o = {{24{ld_byte[7] & sext}}, ld_byte};
      SZ_H:    ld_data_o = {{16{ld_half[15] & sext}}, ld_half};
      default: ld_data_o = ld_word_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: captures a core request, runs one
// valid/ready transaction to data memory, and returns an extended load
// word with a one-cycle completion pulse. Stalls the core through busy.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              busy,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  lsu_state_e        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              tmo;
  logic [3:0]        lane_be;
  logic [31:0]       lane_st_word;
  logic [31:0]       lane_ld_data;

  // Last permitted cycle in ISSUE/WAIT_R; the next edge ends the op with an error
  assign tmo = (cnt_q == TMO_LAST);

  lsu_lane_align u_lane_align (
    .we_i       (we_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .off_i      (addr_q[1:0]),
    .st_data_i  (wdata_q),
    .ld_word_i  (mem_rdata),
    .be_o       (lane_be),
    .st_word_o  (lane_st_word),
    .ld_data_o  (lane_ld_data)
  );

  // Control state: FSM, timeout counter and error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Captured request and load result; only visible through state-gated outputs
  always_ff @(posedge clk) begin
    we_q    <= we_d;
    size_q  <= size_d;
    uns_q   <= uns_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    rdata_q <= rdata_d;
  end

  // Next-state logic with request capture, timeout and load-data capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = is_misaligned(req_size, req_addr[1:0]) ? ST_ERR : ST_ISSUE;
        end
      end
      ST_ERR: begin
        err_d   = 1'b1;
        state_d = ST_DONE;
      end
      ST_ISSUE: begin
        cnt_d = cnt_q + 8'd1;
        if (mem_ready) begin
          if (we_q) begin
            state_d = ST_DONE;
          end else if (mem_rvalid) begin
            rdata_d = lane_ld_data;
            state_d = ST_DONE;
          end else if (tmo) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT_R;
          end
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_WAIT_R: begin
        cnt_d = cnt_q + 8'd1;
        if (mem_rvalid) begin
          rdata_d = lane_ld_data;
          state_d = ST_DONE;
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from state so reset zeroes them without a clock
  always_comb begin
    busy      = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    mem_valid = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      ST_IDLE: begin
        busy = req_valid & rst_n;
      end
      ST_ISSUE: begin
        busy      = 1'b1;
        mem_valid = 1'b1;
        mem_we    = we_q;
        mem_be    = lane_be;
        mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
        mem_wdata = lane_st_word;
      end
      ST_WAIT_R, ST_ERR: begin
        busy = 1'b1;
      end
      ST_DONE: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        rsp_rdata = rdata_q;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed scenarios plus randomized
// operations checked against a byte-lane reference model.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        busy;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  load_store_unit #(.TIMEOUT(16), .ADDR_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .busy         (busy),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_we       (mem_we),
    .mem_be       (mem_be),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] sz);
    case (sz)
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic ref_mis(input logic [1:0] sz, input logic [31:0] a);
    int n;
    n = nbytes(sz);
    if (n == 0) return 1'b1;
    return (a % n) != 0;
  endfunction

  function automatic logic [3:0] ref_be(input logic we, input logic [1:0] sz, input logic [31:0] a);
    int n;
    longint m;
    if (!we) return 4'hF;
    n = nbytes(sz);
    m = ((64'd1 << n) - 1) << (a % 4);
    return 4'(m);
  endfunction

  function automatic logic [31:0] ref_wd(input logic [1:0] sz, input logic [31:0] d);
    int n;
    longint low, r;
    n   = nbytes(sz);
    low = longint'(d) & ((64'd1 << (8 * n)) - 1);
    r   = 0;
    for (int k = 0; k < 4; k += n) r = r | (low << (8 * k));
    return 32'(r);
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic uns,
                                           input logic [31:0] a, input logic [31:0] w);
    int n;
    longint v;
    n = nbytes(sz);
    if (n == 4) return w;
    v = (longint'(w) >> (8 * (a % 4))) & ((64'd1 << (8 * n)) - 1);
    if (!uns && v[8*n-1]) v = v - (64'd1 << (8 * n));
    return 32'(v);
  endfunction

  // ---------------- transaction driver / memory responder ----------------
  // Issues one request from an IDLE negedge and plays the memory side:
  // ready after rdy_wait ISSUE cycles, rvalid rv_wait cycles after the handshake.
  task automatic run_op(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int rdy_wait, input int rv_wait, input logic [31:0] rdat,
                        output int lat, output logic err, output logic [31:0] rd,
                        output logic saw_mem, output logic [31:0] m_addr,
                        output logic [3:0] m_be, output logic [31:0] m_wd, output logic m_we,
                        output logic stable, output logic busy_ok, output logic mv_done,
                        output logic pulse_ok);
    int  cyc, vcnt, hs_cyc;
    logic hs;
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    #1;
    busy_ok = (busy === 1'b1);
    cyc = 0; vcnt = 0; hs = 1'b0; hs_cyc = 0; lat = -1;
    err = 1'b0; rd = '0; saw_mem = 1'b0; stable = 1'b1; mv_done = 1'b0; pulse_ok = 1'b0;
    m_addr = '0; m_be = '0; m_wd = '0; m_we = 1'b0;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      req_valid = 1'b0; req_we = $urandom; req_size = 2'($urandom);
      req_unsigned = $urandom; req_addr = $urandom; req_wdata = $urandom;
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      if (rsp_valid === 1'b1) begin
        lat = cyc; err = rsp_err; rd = rsp_rdata; mv_done = mem_valid;
        if (busy !== 1'b0) busy_ok = 1'b0;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (mem_valid === 1'b1) begin
        if (!saw_mem) begin
          m_addr = mem_addr; m_be = mem_be; m_wd = mem_wdata; m_we = mem_we;
        end else if (m_addr !== mem_addr || m_be !== mem_be || m_wd !== mem_wdata || m_we !== mem_we) begin
          stable = 1'b0;
        end
        saw_mem = 1'b1;
        if (vcnt >= rdy_wait) begin
          mem_ready = 1'b1; hs = 1'b1; hs_cyc = cyc;
        end
        vcnt++;
      end
      if (hs && !m_we && (cyc - hs_cyc) == rv_wait) begin
        mem_rvalid = 1'b1; mem_rdata = rdat;
      end
    end
    @(negedge clk);
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    pulse_ok = (rsp_valid === 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++; if (busy !== 1'b0) begin $display("FAIL rst_busy got=%b exp=0", busy); failures++; end
    checks++; if (rsp_valid !== 1'b0) begin $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); failures++; end
    checks++; if (mem_valid !== 1'b0) begin $display("FAIL rst_mem_valid got=%b exp=0", mem_valid); failures++; end
    checks++; if (rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
      $display("FAIL rst_rsp got err=%b rdata=%h exp err=0 rdata=0", rsp_err, rsp_rdata); failures++; end
    checks++; if (mem_be !== 4'h0 || mem_addr !== 32'h0 || mem_we !== 1'b0) begin
      $display("FAIL rst_mem_bus got be=%h addr=%h we=%b exp 0", mem_be, mem_addr, mem_we); failures++; end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      $display("FAIL idle_after_rst got busy=%b rsp_valid=%b exp 0 0", busy, rsp_valid); failures++; end
  endtask

  task automatic test_store_byte();
    int lat; logic err, sm, st, bo, mvd, po, mwe; logic [31:0] rd, ma, mw; logic [3:0] mb;
    run_op(1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00A5, 0, 0, 32'h0,
           lat, err, rd, sm, ma, mb, mw, mwe, st, bo, mvd, po);
    checks++; if (lat !== 2) begin $display("FAIL sb_latency got=%0d exp=2", lat); failures++; end
    checks++; if (err !== 1'b0) begin $display("FAIL sb_err got=%b exp=0", err); failures++; end
    checks++; if (ma !== 32'h0000_1000) begin $display("FAIL sb_addr got=%h exp=00001000", ma); failures++; end
    checks++; if (mb !== 4'b1000) begin $display("FAIL sb_be got=%b exp=1000", mb); failures++; end
    checks++; if (mw !== 32'hA5A5_A5A5) begin $display("FAIL sb_wdata got=%h exp=a5a5a5a5", mw); failures++; end
    checks++; if (mwe !== 1'b1) begin $display("FAIL sb_we got=%b exp=1", mwe); failures++; end
    checks++; if (rd !== 32'h0) begin $display("FAIL sb_rdata got=%h exp=0", rd); failures++; end
    checks++; if (!bo || !po) begin $display("FAIL sb_busy_pulse got busy_ok=%b pulse_ok=%b exp 1 1", bo, po); failures++; end
  endtask

  task automatic test_load_half();
    int lat; logic err, sm, st, bo, mvd, po, mwe; logic [31:0] rd, ma, mw; logic [3:0] mb;
    run_op(1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0, 0, 1, 32'h8001_1234,
           lat, err, rd, sm, ma, mb, mw, mwe, st, bo, mvd, po);
    checks++; if (lat !== 3) begin $display("FAIL lh_latency got=%0d exp=3", lat); failures++; end
    checks++; if (rd !== 32'hFFFF_8001) begin $display("FAIL lh_signed got=%h exp=ffff8001", rd); failures++; end
    checks++; if (mb !== 4'hF || mwe !== 1'b0 || ma !== 32'h0000_2000) begin
      $display("FAIL lh_bus got be=%h we=%b addr=%h exp f 0 00002000", mb, mwe, ma); failures++; end
    run_op(1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0, 0, 1, 32'h8001_1234,
           lat, err, rd, sm, ma, mb, mw, mwe, st, bo, mvd, po);
    checks++; if (rd !== 32'h0000_8001) begin $display("FAIL lh_unsigned got=%h exp=00008001", rd); failures++; end
    checks++; if (err !== 1'b0 || !po) begin $display("FAIL lh_err_pulse got err=%b pulse_ok=%b exp 0 1", err, po); failures++; end
  endtask

  task automatic test_misaligned();
    int lat; logic err, sm, st, bo, mvd, po, mwe; logic [31:0] rd, ma, mw; logic [3:0] mb;
    run_op(1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'h0, 0, 0, 32'h1234_5678,
           lat, err, rd, sm, ma, mb, mw, mwe, st, bo, mvd, po);
    checks++; if (sm !== 1'b0) begin $display("FAIL mis_mem_valid got=%b exp=0", sm); failures++; end
    checks++; if (lat !== 2) begin $display("FAIL mis_latency got=%0d exp=2", lat); failures++; end
    checks++; if (err !== 1'b1) begin $display("FAIL mis_err got=%b exp=1", err); failures++; end
    checks++; if (rd !== 32'h0) begin $display("FAIL mis_rdata got=%h exp=0", rd); failures++; end
    checks++; if (!bo) begin $display("FAIL mis_busy got=0 exp=1 until done"); failures++; end
  endtask

  task automatic test_backpressure();
    int lat; logic err, sm, st, bo, mvd, po, mwe; logic [31:0] rd, ma, mw, dat; logic [3:0] mb;
    dat = $urandom;
    run_op(1'b0, 2'b10, 1'b0, 32'h0000_4008, 32'h0, 5, 1, dat,
           lat, err, rd, sm, ma, mb, mw, mwe, st, bo, mvd, po);
    checks++; if (!st) begin $display("FAIL bp_stable got=0 exp=1"); failures++; end
    checks++; if (!bo) begin $display("FAIL bp_busy got=0 exp=1 while outstanding"); failures++; end
    checks++; if (rd !== dat) begin $display("FAIL bp_rdata got=%h exp=%h", rd, dat); failures++; end
    checks++; if (lat !== 8) begin $display("FAIL bp_latency got=%0d exp=8", lat); failures++; end
    checks++; if (ma !== 32'h0000_4008 || err !== 1'b0) begin
      $display("FAIL bp_addr_err got addr=%h err=%b exp 00004008 0", ma, err); failures++; end
  endtask

  task automatic test_timeout();
    int lat; logic err, sm, st, bo, mvd, po, mwe; logic [31:0] rd, ma, mw; logic [3:0] mb;
    run_op(1'b0, 2'b10, 1'b0, 32'h0000_5000, 32'h0, 100000, 0, 32'hFFFF_FFFF,
           lat, err, rd, sm, ma, mb, mw, mwe, st, bo, mvd, po);
    checks++; if (lat !== 17) begin $display("FAIL tmo_latency got=%0d exp=17", lat); failures++; end
    checks++; if (err !== 1'b1) begin $display("FAIL tmo_err got=%b exp=1", err); failures++; end
    checks++; if (rd !== 32'h0) begin $display("FAIL tmo_rdata got=%h exp=0", rd); failures++; end
    checks++; if (mvd !== 1'b0 || sm !== 1'b1) begin
      $display("FAIL tmo_mem_valid got done=%b seen=%b exp 0 1", mvd, sm); failures++; end
  endtask

  task automatic test_reset_mid();
    int lat; logic err, sm, st, bo, mvd, po, mwe; logic [31:0] rd, ma, mw; logic [3:0] mb;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h0000_0060; req_wdata = 32'h0; mem_ready = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk); req_valid = 1'b0;
    checks++; if (mem_valid !== 1'b1) begin $display("FAIL rmid_issue got mem_valid=%b exp=1", mem_valid); failures++; end
    #2 rst_n = 1'b0; #1;
    checks++; if (mem_valid !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL rmid_issue_rst got mem_valid=%b busy=%b exp 0 0", mem_valid, busy); failures++; end
    @(negedge clk); rst_n = 1'b1;
    req_valid = 1'b1; req_addr = 32'h0000_0064;
    @(negedge clk); req_valid = 1'b0; mem_ready = 1'b1;
    @(negedge clk); mem_ready = 1'b0;
    checks++; if (busy !== 1'b1 || mem_valid !== 1'b0) begin
      $display("FAIL rmid_wait got busy=%b mem_valid=%b exp 1 0", busy, mem_valid); failures++; end
    #2 rst_n = 1'b0; #1;
    checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      $display("FAIL rmid_wait_rst got busy=%b rsp_valid=%b exp 0 0", busy, rsp_valid); failures++; end
    @(negedge clk); rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk); mem_rvalid = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL rmid_stray_rvalid got rsp_valid=%b busy=%b exp 0 0", rsp_valid, busy); failures++; end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin $display("FAIL rmid_stray_rsp got=%b exp=0", rsp_valid); failures++; end
    run_op(1'b0, 2'b00, 1'b0, 32'h0000_0061, 32'h0, 0, 1, 32'h1234_AB00,
           lat, err, rd, sm, ma, mb, mw, mwe, st, bo, mvd, po);
    checks++; if (lat !== 3 || err !== 1'b0 || rd !== 32'hFFFF_FFAB) begin
      $display("FAIL rmid_next got lat=%0d err=%b rdata=%h exp 3 0 ffffffab", lat, err, rd); failures++; end
  endtask

  task automatic test_random();
    int lat, rdy, rv, elat; logic err, sm, st, bo, mvd, po, mwe;
    logic [31:0] rd, ma, mw, a, d, rdat; logic [3:0] mb; logic we, uns, mis; logic [1:0] sz;
    for (int i = 0; i < 60; i++) begin
      we = $urandom; uns = $urandom; sz = 2'($urandom);
      a = $urandom; d = $urandom; rdat = $urandom;
      rdy = $urandom_range(0, 3); rv = $urandom_range(0, 3);
      run_op(we, sz, uns, a, d, rdy, rv, rdat,
             lat, err, rd, sm, ma, mb, mw, mwe, st, bo, mvd, po);
      mis = ref_mis(sz, a);
      elat = mis ? 2 : (we ? rdy + 2 : rdy + rv + 2);
      checks++; if (lat !== elat) begin $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, lat, elat); failures++; end
      checks++; if (err !== mis) begin $display("FAIL rnd%0d_err got=%b exp=%b", i, err, mis); failures++; end
      checks++; if (rd !== ((mis || we) ? 32'h0 : ref_load(sz, uns, a, rdat))) begin
        $display("FAIL rnd%0d_rdata got=%h exp=%h", i, rd, (mis || we) ? 32'h0 : ref_load(sz, uns, a, rdat)); failures++; end
      checks++; if (sm !== !mis) begin $display("FAIL rnd%0d_mem_seen got=%b exp=%b", i, sm, !mis); failures++; end
      checks++; if (!bo || !po || !st) begin
        $display("FAIL rnd%0d_ctrl got busy_ok=%b pulse_ok=%b stable=%b exp 1 1 1", i, bo, po, st); failures++; end
      if (!mis) begin
        checks++; if (ma !== {a[31:2], 2'b00} || mwe !== we) begin
          $display("FAIL rnd%0d_addr_we got=%h/%b exp=%h/%b", i, ma, mwe, {a[31:2], 2'b00}, we); failures++; end
        checks++; if (mb !== ref_be(we, sz, a)) begin
          $display("FAIL rnd%0d_be got=%b exp=%b", i, mb, ref_be(we, sz, a)); failures++; end
        if (we) begin
          checks++; if (mw !== ref_wd(sz, d)) begin
            $display("FAIL rnd%0d_wdata got=%h exp=%h", i, mw, ref_wd(sz, d)); failures++; end
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    @(negedge clk); @(negedge clk);
    test_reset();
    test_store_byte();
    test_load_half();
    test_misaligned();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Multi-cycle load/store unit between the core's register file and a variable-latency data memory. It takes the load address and store data the register file produces, runs a valid/ready transaction to memory, and returns a size-aligned, sign/zero-extended load word for register write-back (write_data_dm path). It stalls the single-cycle core via busy while a transaction is outstanding. It flags misaligned accesses and memory timeouts.

Parameters:
TIMEOUT, 16, max cycles spent in ISSUE+WAIT_R before aborting with error (2..255)
ADDR_W, 32, byte address width

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  1  core requests a memory op this cycle
req_we  in  1  1=store, 0=load
req_size  in  2  00=byte, 01=half, 10=word, 11=illegal (treated as misaligned)
req_unsigned  in  1  load zero-extends when 1 (LBU/LHU)
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data (low bytes significant for B/H)
busy  out  1  stall core PC/write-back
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  32  extended load data; 0 for stores/errors
rsp_err  out  1  misaligned or timeout, qualified by rsp_valid
mem_valid  out  1  memory request
mem_ready  in  1  memory accepts request
mem_we  out  1  write enable
mem_be  out  4  byte enables
mem_addr  out  ADDR_W  word-aligned address (low 2 bits 0)
mem_wdata  out  32  lane-replicated store data
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read data word

Behaviour:
- Reset (async, rst_n low): state=IDLE, timeout counter=0, all outputs 0. Reset mid-transaction abandons the op; mem_valid drops without waiting for a clock.
- States: IDLE, ISSUE, WAIT_R, ERR, DONE.
- IDLE, req_valid=1: capture all req_* fields. Misaligned when half has addr[0]=1, word has addr[1:0]!=0, or size=11. Misaligned -> ERR. Otherwise -> ISSUE.
- ERR: no memory access; -> DONE with err=1.
- ISSUE: mem_valid=1. addr/we/be/wdata stay stable until mem_ready. On handshake, store -> DONE. Load -> WAIT_R, except mem_rvalid in the same cycle goes directly to DONE with that data.
- WAIT_R: on mem_rvalid, capture mem_rdata -> DONE.
- Timeout: counter clears on IDLE exit and increments each cycle in ISSUE/WAIT_R. Reaching TIMEOUT -> DONE with err=1, rdata=0, mem_valid dropped.
- DONE: rsp_valid=1 for exactly one cycle, then -> IDLE. req_valid is ignored in DONE.
- busy is combinational: 1 in IDLE when req_valid=1, and 1 in ISSUE, WAIT_R, ERR. It is 0 in DONE and in idle IDLE.
- mem_rvalid outside ISSUE/WAIT_R is ignored.
- Store lanes:
  - B: wdata={4{d[7:0]}}, be=0001<<addr[1:0].
  - H: wdata={2{d[15:0]}}, be=0011 (addr[1]=0) or 1100.
  - W: be=1111.
  - Loads: be=1111, we=0.
- Load extract: select byte/half by captured addr[1:0], then sign- or zero-extend per req_unsigned. Word is passed through.
- Latency with zero-wait memory:
  - Store: req cycle 0, ISSUE 1, rsp_valid 2.
  - Load with rvalid one cycle after ready: rsp_valid 3.

Decomposition:
- lsu_pkg: size encodings (SZ_B/SZ_H/SZ_W), state enum, default TIMEOUT.
- Sub-module lsu_lane_align: combinational; store replication + byte enables, and load extract/extend. Instantiated once.

Test Plan:
- Store byte: addr=0x1003, wdata=0x000000A5, size=B, mem_ready=1 -> mem_addr=0x1000, be=1000, wdata=0xA5A5A5A5, rsp_valid at cycle 2, err=0.
- Signed half load: addr=0x2002, mem_rdata=0x8001_1234 -> rsp_rdata=0xFFFF8001. Same access with req_unsigned=1 -> 0x00008001.
- Misaligned word: addr=0x3001 -> no mem_valid ever, rsp_valid=1 and rsp_err=1 at cycle 2, rdata=0.
- Backpressure: mem_ready low 5 cycles on a word load -> mem_* stable throughout, busy=1, correct data after rvalid.
- Timeout: mem_ready never asserted, TIMEOUT=16 -> rsp_err=1 exactly 16 cycles after ISSUE entry, mem_valid then 0.
- Reset mid-WAIT_R: rst_n low -> busy/mem_valid=0 immediately. A later rvalid is ignored, and the next request completes normally.
